// File: rtl/seg_to_hex_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_to_hex_capture
// Purpose  : Recovers per-digit hex values from a multiplexed active-low
//            seven-segment bus using a stability-counter debounce.
// Revision : 1.0 - initial release
// ============================================================================
module seg_to_hex_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                                          clk,
  input  logic                                          resetN,
  input  logic [6:0]                                    iSEG,
  input  logic [DIGITS-1:0]                             iSEL,
  input  logic                                          iCLR_ERR,
  output logic [4*DIGITS-1:0]                           oDIGITS,
  output logic [DIGITS-1:0]                             oVALID,
  output logic                                          oUPD,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] oUPD_IDX,
  output logic                                          oERR
);

  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_zero   = '0;

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_count    = 2'd1;
  localparam logic [1:0] c_st_captured = 2'd2;

  // Returns {legal, value}; the segment lines are active-low, bit6=g .. bit0=a
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b1, 4'h0};
      7'b1111001: res = {1'b1, 4'h1};
      7'b0100100: res = {1'b1, 4'h2};
      7'b0110000: res = {1'b1, 4'h3};
      7'b0011001: res = {1'b1, 4'h4};
      7'b0010010: res = {1'b1, 4'h5};
      7'b0000010: res = {1'b1, 4'h6};
      7'b1111000: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0011000: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b0000011: res = {1'b1, 4'hB};
      7'b1000110: res = {1'b1, 4'hC};
      7'b0100001: res = {1'b1, 4'hD};
      7'b0000110: res = {1'b1, 4'hE};
      7'b0001110: res = {1'b1, 4'hF};
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [1:0]          r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [6:0]          r_prev_seg;
  logic [DIGITS-1:0]   r_prev_sel;
  logic                r_upd;
  logic [c_idx_w-1:0]  r_upd_idx;
  logic                r_err;

  logic [1:0]          w_state_nx;
  logic [c_cnt_w-1:0]  w_cnt_nx;
  logic                w_onehot;
  logic                w_same;
  logic                w_capture;
  logic [4:0]          w_dec;
  logic                w_legal;
  logic [3:0]          w_val;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_cur_valid;
  logic [3:0]          w_cur_val;
  logic                w_upd;
  logic                w_wr_illegal;
  logic [4*DIGITS-1:0] w_digits;
  logic [DIGITS-1:0]   w_valid;

  always_comb begin
    w_onehot = $onehot(iSEL);
    w_same   = (iSEG == r_prev_seg) && (iSEL == r_prev_sel);
    w_dec    = f_decode(iSEG);
    w_legal  = w_dec[4];
    w_val    = w_dec[3:0];
  end

  // Selected digit and its currently stored contents
  always_comb begin
    w_idx       = '0;
    w_cur_valid = 1'b0;
    w_cur_val   = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (iSEL[i]) begin
        w_idx       = c_idx_w'(i);
        w_cur_valid = w_valid[i];
        w_cur_val   = w_digits[4*i +: 4];
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_onehot) begin
          w_state_nx = c_st_count;
          w_cnt_nx   = c_one;
        end else begin
          w_cnt_nx   = c_zero;
        end
      end
      c_st_count: begin
        if (w_same) begin
          w_cnt_nx   = r_cnt + c_one;
        end else if (w_onehot) begin
          w_cnt_nx   = c_one;
        end else begin
          w_state_nx = c_st_idle;
          w_cnt_nx   = c_zero;
        end
      end
      c_st_captured: begin
        if (!w_same) begin
          if (w_onehot) begin
            w_state_nx = c_st_count;
            w_cnt_nx   = c_one;
          end else begin
            w_state_nx = c_st_idle;
            w_cnt_nx   = c_zero;
          end
        end
      end
      default: begin
        w_state_nx = c_st_idle;
        w_cnt_nx   = c_zero;
      end
    endcase
    // The sample that completes the run captures on this same edge
    if ((w_state_nx == c_st_count) && (w_cnt_nx == c_stable)) begin
      w_capture  = 1'b1;
      w_state_nx = c_st_captured;
    end
  end

  always_comb begin
    w_upd        = w_capture && w_legal && (!w_cur_valid || (w_cur_val != w_val));
    w_wr_illegal = w_capture && !w_legal;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= c_st_idle;
      r_cnt      <= c_zero;
      r_prev_seg <= 7'h00;
      r_prev_sel <= '0;
      r_upd      <= 1'b0;
      r_upd_idx  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_prev_seg <= iSEG;
      r_prev_sel <= iSEL;
      r_upd      <= w_upd;
      if (w_upd) begin
        r_upd_idx <= w_idx;
      end
      if (w_wr_illegal) begin
        r_err <= 1'b1;
      end else if (iCLR_ERR) begin
        r_err <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] r_val;
      logic       r_vld;

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          r_val <= 4'h0;
          r_vld <= 1'b0;
        end else if (w_capture && iSEL[gi]) begin
          if (w_legal) begin
            r_val <= w_val;
            r_vld <= 1'b1;
          end else begin
            r_vld <= 1'b0;
          end
        end
      end

      assign w_digits[4*gi +: 4] = r_val;
      assign w_valid[gi]         = r_vld;
    end
  endgenerate

  assign oDIGITS  = w_digits;
  assign oVALID   = w_valid;
  assign oUPD     = r_upd;
  assign oUPD_IDX = r_upd_idx;
  assign oERR     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_to_hex_capture.sv
`default_nettype none
// Testbench for seg_to_hex_capture: two instances (STABLE_CYCLES 8 and 1) share
// stimulus; a run-length reference model feeds per-instance expected-update queues.
module tb_seg_to_hex_capture;

  logic        clk = 1'b0;
  logic        resetN;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic        clr;

  logic [15:0] d0_digits, d1_digits;
  logic [3:0]  d0_valid,  d1_valid;
  logic        d0_upd,    d1_upd;
  logic [1:0]  d0_idx,    d1_idx;
  logic        d0_err,    d1_err;

  always #5 clk = ~clk;

  seg_to_hex_capture #(.DIGITS(4), .STABLE_CYCLES(8)) u_dut0 (
    .clk(clk), .resetN(resetN), .iSEG(seg), .iSEL(sel), .iCLR_ERR(clr),
    .oDIGITS(d0_digits), .oVALID(d0_valid), .oUPD(d0_upd), .oUPD_IDX(d0_idx), .oERR(d0_err)
  );

  seg_to_hex_capture #(.DIGITS(4), .STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .resetN(resetN), .iSEG(seg), .iSEL(sel), .iCLR_ERR(clr),
    .oDIGITS(d1_digits), .oVALID(d1_valid), .oUPD(d1_upd), .oUPD_IDX(d1_idx), .oERR(d1_err)
  );

  int asserts = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;
  int n_upd[2];

  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: run length of the current (seg,sel) combination
  int         m_run  [2];
  bit         m_done [2];
  logic [3:0] m_dig  [2][4];
  bit   [3:0] m_val  [2];
  bit         m_err  [2];
  logic [6:0] m_lseg;
  logic [3:0] m_lsel;
  int         q0[$];
  int         q1[$];

  function automatic int get_n(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (pat[k] == s) return k;
    return -1;
  endfunction

  function automatic logic [15:0] exp_digits(input int k);
    return {m_dig[k][3], m_dig[k][2], m_dig[k][1], m_dig[k][0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_done[k] = 0; m_val[k] = 4'h0; m_err[k] = 0;
      for (int d = 0; d < 4; d++) m_dig[k][d] = 4'h0;
    end
    q0.delete(); q1.delete();
    m_lseg = 7'h00; m_lsel = 4'h0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [3:0] sl, input logic c);
    bit oh, same, cap, up;
    int idx, v;
    if (!resetN) begin
      model_reset();
      return;
    end
    oh   = ($countones(sl) == 1);
    same = (s == m_lseg) && (sl == m_lsel);
    idx  = 0;
    for (int d = 0; d < 4; d++) if (sl[d]) idx = d;
    v = dec(s);
    for (int k = 0; k < 2; k++) begin
      cap = 0;
      if (!oh) begin
        m_run[k] = 0; m_done[k] = 0;
      end else if (same) begin
        m_run[k]++;
      end else begin
        m_run[k] = 1; m_done[k] = 0;
      end
      if (oh && !m_done[k] && m_run[k] >= get_n(k)) begin
        cap = 1; m_done[k] = 1;
      end
      if (cap && v >= 0) begin
        up = !m_val[k][idx] || (m_dig[k][idx] != 4'(v));
        m_dig[k][idx] = 4'(v);
        m_val[k][idx] = 1'b1;
        if (up) begin
          if (k == 0) q0.push_back(idx * 16 + v);
          else        q1.push_back(idx * 16 + v);
        end
      end else if (cap) begin
        m_val[k][idx] = 1'b0;
        m_err[k] = 1;
      end
      if (!(cap && v < 0) && c) m_err[k] = 0;
    end
    m_lseg = s; m_lsel = sl;
  endtask

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic chk(input int k, input logic [15:0] dg, input logic [3:0] vl,
                     input logic up, input logic [1:0] ix, input logic er);
    int  e;
    bit  pend;
    cmp("digits", k, 32'(dg), 32'(exp_digits(k)));
    cmp("valid",  k, 32'(vl), 32'(m_val[k]));
    cmp("err",    k, 32'(er), 32'(m_err[k]));
    pend = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    cmp("upd", k, 32'(up), 32'(pend));
    if (pend) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      cmp("upd_idx", k, 32'(ix), 32'(e / 16));
    end
    if (up === 1'b1) n_upd[k]++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk(0, d0_digits, d0_valid, d0_upd, d0_idx, d0_err);
      chk(1, d1_digits, d1_valid, d1_upd, d1_idx, d1_err);
    end
  end

  task automatic step(input logic [6:0] s, input logic [3:0] sl, input logic c);
    seg = s; sel = sl; clr = c;
    @(posedge clk);
    model_edge(s, sl, c);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] sl, input int n);
    for (int i = 0; i < n; i++) step(s, sl, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_upd[0] = 0; n_upd[1] = 0;
  endtask

  task automatic check_zero(input string name);
    cmp({name, "_digits"}, 0, 32'(d0_digits), 32'h0);
    cmp({name, "_valid"},  0, 32'(d0_valid),  32'h0);
    cmp({name, "_upd"},    0, 32'(d0_upd),    32'h0);
    cmp({name, "_idx"},    0, 32'(d0_idx),    32'h0);
    cmp({name, "_err"},    0, 32'(d0_err),    32'h0);
    cmp({name, "_digits"}, 1, 32'(d1_digits), 32'h0);
    cmp({name, "_valid"},  1, 32'(d1_valid),  32'h0);
    cmp({name, "_err"},    1, 32'(d1_err),    32'h0);
  endtask

  initial begin
    logic [6:0] rs, gs;
    logic [3:0] rsel;
    int len, gpos;

    resetN = 1'b0; seg = 7'h00; sel = 4'h0; clr = 1'b0;
    model_reset();
    clr_counts();
    repeat (3) step(7'h00, 4'h0, 1'b0);
    check_zero("reset");
    resetN = 1'b1;
    chk_en = 1'b1;

    // Single digit held long: exactly one update
    hold(pat[0], 4'b0001, 108);
    settle();
    cmp("hold_upd_count", 0, 32'(n_upd[0]), 32'd1);
    cmp("hold_upd_count", 1, 32'(n_upd[1]), 32'd1);

    // Scan all four digits twice
    clr_counts();
    hold(pat[2],  4'b0001, 20);
    hold(pat[3],  4'b0010, 20);
    hold(pat[10], 4'b0100, 20);
    hold(pat[15], 4'b1000, 20);
    settle();
    cmp("scan_digits", 0, 32'(d0_digits), 32'hFA32);
    cmp("scan_valid",  0, 32'(d0_valid),  32'hF);
    cmp("scan_upd_count", 0, 32'(n_upd[0]), 32'd4);
    clr_counts();
    hold(pat[2],  4'b0001, 20);
    hold(pat[3],  4'b0010, 20);
    hold(pat[10], 4'b0100, 20);
    hold(pat[15], 4'b1000, 20);
    settle();
    cmp("rescan_upd_count", 0, 32'(n_upd[0]), 32'd0);

    // Short dwell and glitched dwells on digit 2
    clr_counts();
    hold(pat[1], 4'b0100, 7);
    step(7'h00, 4'b0000, 1'b0);
    hold(pat[1], 4'b0100, 5);
    hold(pat[7], 4'b0100, 1);
    hold(pat[1], 4'b0100, 6);
    step(7'h00, 4'b0000, 1'b0);
    settle();
    cmp("short_dwell_upd", 0, 32'(n_upd[0]), 32'd0);
    cmp("short_dwell_digits", 0, 32'(d0_digits), 32'hFA32);
    hold(pat[1], 4'b0100, 3);
    hold(pat[7], 4'b0100, 1);
    hold(pat[1], 4'b0100, 8);
    settle();
    cmp("glitch_recover_upd", 0, 32'(n_upd[0]), 32'd1);
    cmp("glitch_recover_digits", 0, 32'(d0_digits), 32'hF132);

    // Illegal patterns and error clear priority
    hold(7'b1111111, 4'b0010, 8);
    step(7'h00, 4'b0000, 1'b0);
    cmp("illegal_err",   0, 32'(d0_err), 32'd1);
    cmp("illegal_valid", 0, 32'(d0_valid[1]), 32'd0);
    cmp("illegal_keep",  0, 32'(d0_digits[7:4]), 32'h3);
    hold(7'b1111110, 4'b0010, 7);
    step(7'b1111110, 4'b0010, 1'b1);
    step(7'h00, 4'b0000, 1'b0);
    cmp("set_beats_clr", 0, 32'(d0_err), 32'd1);
    step(7'h00, 4'b0000, 1'b1);
    step(7'h00, 4'b0000, 1'b0);
    cmp("lone_clr", 0, 32'(d0_err), 32'd0);

    // Non-one-hot selects never capture
    clr_counts();
    hold(pat[8], 4'b0011, 50);
    hold(pat[8], 4'b0000, 50);
    settle();
    cmp("bad_sel_upd", 0, 32'(n_upd[0]), 32'd0);
    cmp("bad_sel_upd", 1, 32'(n_upd[1]), 32'd0);

    // Asynchronous reset in the middle of a dwell
    hold(pat[5], 4'b1000, 4);
    #2 resetN = 1'b0;
    model_reset();
    #1 check_zero("async_rst");
    hold(pat[5], 4'b1000, 2);
    resetN = 1'b1;
    clr_counts();
    hold(pat[5], 4'b1000, 7);
    settle();
    cmp("post_rst_no_cap", 0, 32'(n_upd[0]), 32'd0);
    cmp("post_rst_digits", 0, 32'(d0_digits), 32'h0);
    hold(pat[5], 4'b1000, 1);
    settle();
    cmp("post_rst_cap", 0, 32'(n_upd[0]), 32'd1);
    cmp("post_rst_val", 0, 32'(d0_digits), 32'h5000);

    // Randomized dwells with glitches, illegal patterns and error clears
    for (int t = 0; t < 300; t++) begin
      rsel = ($urandom_range(0, 99) < 85) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      rs   = ($urandom_range(0, 99) < 80) ? pat[$urandom_range(0, 15)] : 7'($urandom);
      gs   = pat[$urandom_range(0, 15)];
      len  = $urandom_range(1, 14);
      gpos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) begin
        if (i == gpos) step(gs, rsel, ($urandom_range(0, 19) == 0));
        else           step(rs, rsel, ($urandom_range(0, 19) == 0));
      end
    end

    settle();
    cmp("queue_drained", 0, 32'(q0.size()), 32'd0);
    cmp("queue_drained", 1, 32'(q1.size()), 32'd0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_to_hex_capture.md
# seg_to_hex_capture

Monitor block that reads a multiplexed, active-low seven-segment display bus and recovers the hex digit shown on each position. It sits beside the score/status display path of the game controller, sampling segment and digit-select lines. It publishes per-digit 4-bit values, valid flags, an update strobe and a sticky illegal-pattern error for self-check and debug readout. The debounce is a stability counter, so select/segment skew and glitches never produce a capture.

## Interface
- DIGITS, 4: number of multiplexed display positions (1..8).
- STABLE_CYCLES, 8: consecutive identical samples required before capture (>=1).
- clk  in  1  system clock, all logic on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- iSEG  in  7  segment lines, active-low; bit6=g … bit0=a.
- iSEL  in  DIGITS  digit select, active-high, legal only when exactly one bit is set.
- iCLR_ERR  in  1  synchronous one-cycle clear of oERR.
- oDIGITS  out  4*DIGITS  decoded values; digit i in bits [4i+3:4i].
- oVALID  out  DIGITS  digit i holds a legally decoded value.
- oUPD  out  1  one-cycle pulse when a stored digit is written with a new value or becomes valid.
- oUPD_IDX  out  $clog2(DIGITS) (min 1)  index written when oUPD=1; holds last value otherwise.
- oERR  out  1  sticky: an illegal pattern was captured.

## Operation
- Input stage: iSEG/iSEL registered every cycle into prev_seg/prev_sel; run counter cnt, width $clog2(STABLE_CYCLES+1), saturates at STABLE_CYCLES.
- Decode table (iSEG -> value): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9, 0001000=A, 0000011=b, 1000110=C, 0100001=d, 0000110=E, 0001110=F. Any other pattern is illegal.
- FSM states:
  - IDLE: iSEL not one-hot (zero or multiple bits). cnt=0. Go to COUNT when iSEL becomes one-hot, with cnt=1.
  - COUNT: if (iSEG,iSEL) equals previous sample, increment cnt. If it differs, restart with cnt=1, or go to IDLE if the new iSEL is illegal. When the sample that makes cnt reach STABLE_CYCLES is taken, perform a capture and go to CAPTURED.
  - CAPTURED: hold while inputs are unchanged; no further writes. On any change, go to COUNT with cnt=1, or to IDLE if iSEL is illegal.
- Capture of digit i = index of the iSEL bit:
  - Legal pattern: write value. Set oVALID[i]. Pulse oUPD with oUPD_IDX=i if oVALID[i] was 0 or the value differs.
  - Illegal pattern: oDIGITS[i] unchanged, oVALID[i] cleared, oERR set, no oUPD.
- Each dwell produces at most one capture, so a display holding one digit forever generates one oUPD only.
- oERR: set on illegal capture, cleared by iCLR_ERR. If both occur in the same cycle, the set wins.
- STABLE_CYCLES=1: capture on the first sample of each new (iSEG,iSEL) combination.

## Timing
- Reset (resetN=0, asynchronous): state IDLE, cnt=0, prev regs=0, oDIGITS=0, oVALID=0, oUPD=0, oUPD_IDX=0, oERR=0. Reset mid-dwell discards the run. After release, a full STABLE_CYCLES run is needed.
- Latency: if the inputs are legal and constant at edges E..E+N-1 (N=STABLE_CYCLES), the capture registers at edge E+N-1. oDIGITS/oVALID/oUPD/oERR are visible in the following cycle.
- A single-cycle change at any point restarts the count; a glitch shorter than N samples never writes.
- oUPD is high for exactly one cycle per qualifying capture. Two captures are at least N cycles apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then iSEL=0001, iSEG=1000000 held 8 cycles -> oDIGITS[3:0]=0, oVALID=0001, oUPD single pulse with oUPD_IDX=0, exactly 8 cycles after the first sample. Holding for 100 more cycles produces no further oUPD.
- Scan iSEL 0001/0010/0100/1000 with patterns 0100100/0110000/0001000/0001110, 20-cycle dwells -> oDIGITS=16'hFA32, oVALID=1111, four oUPD pulses (idx 0,1,2,3). A second identical scan produces no oUPD.
- A dwell of 7 cycles (<STABLE_CYCLES) with 1111001 on digit 2 -> no write and no oUPD. A 1-cycle glitch inside a 12-cycle dwell prevents capture unless 8 stable samples follow it.
- Illegal pattern 1111111 stable on digit 1 -> oERR=1, oVALID[1]=0, oDIGITS[7:4] unchanged. iCLR_ERR coinciding with a new illegal capture leaves oERR=1. A later lone iCLR_ERR clears it.
- iSEL=0011 or 0000 held 50 cycles -> no capture and no outputs change. With STABLE_CYCLES=1, each new legal sample captures the next cycle.
- resetN pulled low at cycle 5 of an 8-cycle dwell -> all outputs 0 asynchronously. After release, the capture occurs only after 8 fresh stable samples.
